// File: rtl/ct_spsram_ctrl_pkg.sv
// rtl/ct_spsram_ctrl_pkg.sv - shared types, defaults and byte-mask expansion for the SRAM access sequencer
package ct_spsram_ctrl_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 128;
    localparam int DEF_TAG_W  = 4;

    // Per-bit active-low write enable; every bit stays high (masked) on reads.
    function automatic logic [DEF_DATA_W-1:0] bmask_to_wen(input logic wr,
                                                           input logic [DEF_DATA_W/8-1:0] bmask);
        logic [DEF_DATA_W-1:0] wen;
        for (int i = 0; i < DEF_DATA_W; i++) begin
            wen[i] = ~(wr & bmask[i/8]);
        end
        return wen;
    endfunction

endpackage

// File: rtl/ct_spsram_ctrl_rspfifo.sv
// rtl/ct_spsram_ctrl_rspfifo.sv - registered {tag, data} response FIFO with occupancy count
module ct_spsram_ctrl_rspfifo #(
    parameter int WIDTH = 132,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_tvalid,
    input  logic [WIDTH-1:0] s_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [WIDTH-1:0] m_tdata,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    // Overflow is prevented upstream by the credit check, so pushes are unconditional.
    assign do_pop   = m_tvalid && m_tready;
    assign m_tvalid = (count != '0);
    assign m_tdata  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (s_tvalid) begin
            mem[wr_ptr] <= s_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (s_tvalid) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(s_tvalid) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/ct_spsram_65536x128_ctrl.sv
// rtl/ct_spsram_65536x128_ctrl.sv - request-stream to single-port SRAM sequencer; CT_SPSRAM_CTRL_INIT_EN adds a zeroing sweep after reset
module ct_spsram_65536x128_ctrl
    import ct_spsram_ctrl_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int TAG_W     = DEF_TAG_W,
    parameter int RSP_DEPTH = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wr,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_bmask,
    input  logic [TAG_W-1:0]    req_tag,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [TAG_W-1:0]    rsp_tag,
    output logic                init_done,
    output logic [ADDR_W-1:0]   sram_A,
    output logic                sram_CEN,
    output logic                sram_GWEN,
    output logic [DATA_W-1:0]   sram_WEN,
    output logic [DATA_W-1:0]   sram_D,
    input  logic [DATA_W-1:0]   sram_Q
);

    localparam int CNT_W = $clog2(RSP_DEPTH) + 1;
    localparam int MW    = DEF_DATA_W / 8;
    localparam logic [CNT_W:0] DEPTH_L = RSP_DEPTH[CNT_W:0];

    state_t              state;
    state_t              state_next;
    logic                accept;
    logic                rd_inflight;
    logic [TAG_W-1:0]    tag_q;
    logic [CNT_W-1:0]    fifo_count;
    logic [CNT_W:0]      used;
    logic [DEF_DATA_W-1:0] wen_full;
`ifdef CT_SPSRAM_CTRL_INIT_EN
    logic [ADDR_W-1:0]   sweep_cnt;
`endif

    // A read holds a credit from acceptance until its data lands in the FIFO.
    assign used      = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rd_inflight};
    assign req_ready = !RST && init_done && (state == RUN) && (used < DEPTH_L);
    assign accept    = req_valid && req_ready;
    assign wen_full  = bmask_to_wen(req_wr, MW'(req_bmask));

    always_comb begin
        state_next = state;
        sram_CEN   = 1'b1;
        sram_GWEN  = 1'b1;
        sram_WEN   = '1;
        sram_A     = '0;
        sram_D     = '0;
`ifdef CT_SPSRAM_CTRL_INIT_EN
        if (state == INIT && sweep_cnt == '1) begin
            state_next = RUN;
        end
`else
        state_next = RUN;
`endif
        if (accept) begin
            sram_CEN  = 1'b0;
            sram_GWEN = ~req_wr;
            sram_WEN  = wen_full[DATA_W-1:0];
            sram_A    = req_addr;
            sram_D    = req_wdata;
        end
`ifdef CT_SPSRAM_CTRL_INIT_EN
        else if (!RST && state == INIT) begin
            sram_CEN  = 1'b0;
            sram_GWEN = 1'b0;
            sram_WEN  = '0;
            sram_A    = sweep_cnt;
            sram_D    = '0;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
`ifdef CT_SPSRAM_CTRL_INIT_EN
            state     <= INIT;
            sweep_cnt <= '0;
`else
            state     <= RUN;
`endif
            init_done   <= 1'b0;
            rd_inflight <= 1'b0;
            tag_q       <= '0;
        end else begin
            state       <= state_next;
            init_done   <= (state_next == RUN);
            rd_inflight <= accept && !req_wr;
            if (accept && !req_wr) begin
                tag_q <= req_tag;
            end
`ifdef CT_SPSRAM_CTRL_INIT_EN
            if (state == INIT) begin
                sweep_cnt <= sweep_cnt + ADDR_W'(1);
            end
`endif
        end
    end

    // SRAM Q is valid the cycle after a read is accepted; capture it with its tag.
    ct_spsram_ctrl_rspfifo #(
        .WIDTH (TAG_W + DATA_W),
        .DEPTH (RSP_DEPTH)
    ) u_rspfifo (
        .clk      (CLK),
        .rst      (RST),
        .s_tvalid (rd_inflight),
        .s_tdata  ({tag_q, sram_Q}),
        .m_tvalid (rsp_valid),
        .m_tready (rsp_ready),
        .m_tdata  ({rsp_tag, rsp_rdata}),
        .count    (fifo_count)
    );

endmodule
